// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid check controller: FSM state encoding,
// default expected ID/timestamp values and counter widths.
package sysid_check_pkg;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1446094586;

  localparam int RETRY_W = 4;
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    RD_TS   = 3'd2,
    COMPARE = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sysid_check_timer.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero.
module sysid_check_timer
  import sysid_check_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads the sysid slave over Avalon-MM after reset (or on start), compares against
// expected values and retries with a gap. Timestamp check enabled by SYSID_CHECK_TS_EN.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS = DEF_EXPECTED_TS,
  parameter int          MAX_RETRY   = 3,
  parameter int          RETRY_GAP   = 16,
  parameter int          TIMEOUT     = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        fail,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output state_t      dbg_state
);

  // Handshake: a read word is accepted in the cycle where avm_read=1 and
  // avm_waitrequest=0; while waitrequest=1 address and read stay unchanged.

  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
  localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(RETRY_GAP - 1);
  localparam logic [TIMER_W-1:0] TMO_LOAD    = TIMER_W'(TIMEOUT - 1);

`ifdef SYSID_CHECK_TS_EN
  localparam state_t AFTER_ID = RD_TS;
`else
  localparam state_t AFTER_ID = COMPARE;
`endif

  state_t             state_q;
  logic [RETRY_W-1:0] retry_q;
  logic               done_q;
  logic               fail_q;
  logic               id_ok_q;
  logic               ts_ok_q;
  logic [31:0]        id_value_q;

  logic               tmr_load;
  logic               tmr_dec;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;

  logic               in_read;
  logic               rd_timeout;
  logic               id_match;
  logic               ts_match;
  logic               can_retry;
  logic               attempt_end;
  logic               attempt_pass;

`ifdef SYSID_CHECK_TS_EN
  logic [31:0]        ts_value_q;
  assign ts_match = (ts_value_q == EXPECTED_TS);
  assign ts_value = ts_value_q;
`else
  logic               unused_ts_ref;
  assign unused_ts_ref = ^EXPECTED_TS;
  assign ts_match      = 1'b1;
  assign ts_value      = '0;
`endif

  assign in_read      = (state_q == RD_ID) || (state_q == RD_TS);
  assign rd_timeout   = in_read && avm_waitrequest && tmr_zero;
  assign id_match     = (id_value_q == EXPECTED_ID);
  assign can_retry    = (retry_q < MAX_RETRY_C);
  assign attempt_end  = (state_q == COMPARE) || rd_timeout;
  assign attempt_pass = (state_q == COMPARE) && id_match && ts_match;

  // One timer serves both the stall timeout and the retry gap: it is reloaded
  // on every entry into a read or gap state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = TMO_LOAD;
    case (state_q)
      IDLE, DONE: tmr_load = 1'b1;
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      COMPARE: begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LOAD;
      end
      GAP: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: tmr_load = 1'b1;
    endcase
  end

  sysid_check_timer u_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      id_value_q <= '0;
`ifdef SYSID_CHECK_TS_EN
      ts_value_q <= '0;
`endif
    end else if (attempt_end) begin
      // A stall timeout ends the attempt like a failed compare.
      id_ok_q <= (state_q == COMPARE) && id_match;
      ts_ok_q <= (state_q == COMPARE) && ts_match;
      if (attempt_pass) begin
        done_q  <= 1'b1;
        fail_q  <= 1'b0;
        state_q <= DONE;
      end else if (can_retry) begin
        retry_q <= retry_q + 1'b1;
        state_q <= GAP;
      end else begin
        done_q  <= 1'b1;
        fail_q  <= 1'b1;
        state_q <= DONE;
      end
    end else begin
      case (state_q)
        IDLE: state_q <= RD_ID;
        RD_ID: begin
          if (!avm_waitrequest) begin
            id_value_q <= avm_readdata;
            state_q    <= AFTER_ID;
          end
        end
`ifdef SYSID_CHECK_TS_EN
        RD_TS: begin
          if (!avm_waitrequest) begin
            ts_value_q <= avm_readdata;
            state_q    <= COMPARE;
          end
        end
`endif
        GAP: begin
          if (tmr_zero) begin
            state_q <= RD_ID;
          end
        end
        DONE: begin
          if (start) begin
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            retry_q <= '0;
            state_q <= RD_ID;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign avm_read    = in_read;
  assign avm_address = (state_q == RD_TS);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = done_q;
  assign fail        = fail_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign id_value    = id_value_q;
  assign dbg_state   = state_q;

endmodule
